// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and baud-timing helpers
// also used by uart_tx.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        PARITY  = 3'd3,
        STOP    = 3'd4,
        RECOVER = 3'd5
    } uart_rx_state;

    function automatic int pulse_width(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    function automatic int cnt_width(input int pulse);
        return $clog2(pulse) + 1;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Generic two-flop synchroniser with configurable reset value; both flops
// hold while ena is low.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic ena,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // metastability chain
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else if (ena) begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with valid/ready output, framing and overrun pulses.
// Optional even parity when UART_RX_PARITY_EN is defined.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BAUD_RATE  = 115_200,
    parameter int CLK_FREQ   = 50_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ena,
    input  logic                  rx_signal,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  rx_frame_err,
    output logic                  rx_overrun
`ifdef UART_RX_PARITY_EN
    ,
    output logic                  rx_parity_err
`endif
);

    localparam int PULSE_WIDTH      = pulse_width(CLK_FREQ, BAUD_RATE);
    localparam int HALF_PULSE_WIDTH = PULSE_WIDTH / 2;
    localparam int CNT_W            = cnt_width(PULSE_WIDTH);
    localparam int BIT_W            = $clog2(DATA_WIDTH);

    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(PULSE_WIDTH - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_PULSE_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);

    logic                  rx_s;
    uart_rx_state          state_q, state_d;
    logic [CNT_W-1:0]      clk_cnt_q, clk_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  ferr_q, ferr_d;
    logic                  ovr_q, ovr_d;
    logic                  accept_s;
    logic                  deliver_s;
`ifdef UART_RX_PARITY_EN
    logic                  par_q, par_d;
    logic                  perr_q, perr_d;
`endif

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .ena   (ena),
        .d_i   (rx_signal),
        .q_o   (rx_s)
    );

    // frame sequencing and output handshake next-state
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = valid_q;
        ferr_d    = 1'b0;
        ovr_d     = 1'b0;
        deliver_s = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d     = par_q;
        perr_d    = 1'b0;
`endif
        accept_s = valid_q && rx_ready;
        if (accept_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d   = START;
                    clk_cnt_d = HALF_LOAD;
                end else begin
                    state_d   = IDLE;
                end
            end
            START: begin
                if (clk_cnt_q == '0) begin
                    if (!rx_s) begin
                        state_d   = DATA;
                        clk_cnt_d = FULL_LOAD;
                        bit_cnt_d = '0;
                    end else begin
                        state_d   = IDLE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q - CNT_ONE;
                end
            end
            DATA: begin
                if (clk_cnt_q == '0) begin
                    shift_d[bit_cnt_q] = rx_s;
                    clk_cnt_d          = FULL_LOAD;
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_ONE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q - CNT_ONE;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (clk_cnt_q == '0) begin
                    par_d     = rx_s;
                    clk_cnt_d = FULL_LOAD;
                    state_d   = STOP;
                end else begin
                    clk_cnt_d = clk_cnt_q - CNT_ONE;
                end
            end
`endif
            STOP: begin
                if (clk_cnt_q == '0) begin
`ifdef UART_RX_PARITY_EN
                    perr_d = ^{shift_q, par_q};
`endif
                    if (rx_s) begin
                        state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                        deliver_s = ~perr_d;
`else
                        deliver_s = 1'b1;
`endif
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = RECOVER;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q - CNT_ONE;
                end
            end
            RECOVER: begin
                if (rx_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = RECOVER;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // a word arriving while the previous one is still unclaimed is dropped
        if (deliver_s) begin
            if (!valid_q || accept_s) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d   = 1'b1;
            end
        end else begin
            data_d = data_q;
        end
    end

    // state and output registers, frozen while ena is low
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q     <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else if (ena) begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
`ifdef UART_RX_PARITY_EN
            par_q     <= par_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign rx_data      = data_q;
    assign rx_valid     = valid_q;
    assign rx_frame_err = ferr_q;
    assign rx_overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
    assign rx_parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 10 clocks per bit (PULSE=10, HALF=5).
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ena = 1'b1;
    logic       rx_signal = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       rx_frame_err;
    logic       rx_overrun;
`ifdef UART_RX_PARITY_EN
    logic       rx_parity_err;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int valid_cycles = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_rx #(
        .DATA_WIDTH (8),
        .BAUD_RATE  (100_000),
        .CLK_FREQ   (1_000_000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ena          (ena),
        .rx_signal    (rx_signal),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun)
`ifdef UART_RX_PARITY_EN
        ,
        .rx_parity_err(rx_parity_err)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // monitor: pops the scoreboard on every accepted word, counts pulses
    always @(negedge clk) begin
        logic [7:0] e;
        if (!reset && ena) begin
            if (rx_valid) valid_cycles++;
            if (rx_frame_err) ferr_cnt++;
            if (rx_overrun) ovr_cnt++;
            if (rx_valid && rx_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_word: got %02h, required none", rx_data);
                end else begin
                    e = exp_q.pop_front();
                    if (rx_data !== e) begin
                        n_bad++;
                        $display("FAIL rx_data: got %02h, required %02h", rx_data, e);
                    end
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // one bit time counted in enabled cycles, so frames stretch with ena low
    task automatic wait_bit();
        int n = 0;
        while (n < 10) begin
            @(posedge clk);
            if (ena) n++;
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_b);
        rx_signal = 1'b0;
        wait_bit();
        for (int i = 0; i < 8; i++) begin
            rx_signal = b[i];
            wait_bit();
        end
        rx_signal = stop_b;
        wait_bit();
        rx_signal = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) cycles(1);
        check("scoreboard_empty", exp_q.size(), 0);
    endtask

    initial begin
        int lat;
        int vc0, fe0, ov0;

        cycles(3);
        check("reset_valid", rx_valid, 0);
        check("reset_data", rx_data, 0);
        check("reset_ferr", rx_frame_err, 0);
        check("reset_ovr", rx_overrun, 0);
        reset = 1'b0;
        cycles(5);

        // A5 with latency measurement
        rx_ready = 1'b1;
        exp_q.push_back(8'hA5);
        vc0 = valid_cycles;
        lat = 0;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                while (lat < 200 && !rx_valid) begin
                    @(posedge clk);
                    lat++;
                    #1;
                end
            end
        join
        check("latency", lat, 98);
        cycles(10);
        check("a5_valid_cycles", valid_cycles - vc0, 1);
        drain();

        // glitch on the idle line
        vc0 = valid_cycles;
        fe0 = ferr_cnt;
        rx_signal = 1'b0;
        cycles(3);
        rx_signal = 1'b1;
        cycles(30);
        check("glitch_no_valid", valid_cycles - vc0, 0);
        check("glitch_no_ferr", ferr_cnt - fe0, 0);

        // framing error then a good frame
        vc0 = valid_cycles;
        fe0 = ferr_cnt;
        send_frame(8'h3C, 1'b0);
        cycles(20);
        check("ferr_pulse", ferr_cnt - fe0, 1);
        check("ferr_no_valid", valid_cycles - vc0, 0);
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1);
        cycles(10);
        drain();

        // overrun: second frame dropped while first unclaimed
        rx_ready = 1'b0;
        ov0 = ovr_cnt;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        cycles(20);
        check("ovr_valid_held", rx_valid, 1);
        check("ovr_data_held", rx_data, 8'h11);
        check("ovr_pulse", ovr_cnt - ov0, 1);
        rx_ready = 1'b1;
        cycles(1);
        rx_ready = 1'b0;
        check("ovr_valid_cleared", rx_valid, 0);
        drain();

        // accept coincides with delivery of the next word
        ov0 = ovr_cnt;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        send_frame(8'h11, 1'b1);
        fork
            send_frame(8'h22, 1'b1);
            begin
                cycles(97);
                rx_ready = 1'b1;
                cycles(1);
                rx_ready = 1'b0;
            end
        join
        cycles(5);
        check("same_cycle_valid", rx_valid, 1);
        check("same_cycle_data", rx_data, 8'h22);
        check("same_cycle_no_ovr", ovr_cnt - ov0, 0);
        rx_ready = 1'b1;
        cycles(1);
        rx_ready = 1'b0;
        drain();

        // reset mid-DATA discards the partial word and clears outputs
        vc0 = valid_cycles;
        rx_signal = 1'b0;
        cycles(40);
        reset = 1'b1;
        rx_signal = 1'b1;
        cycles(2);
        check("midreset_data", rx_data, 0);
        check("midreset_valid", rx_valid, 0);
        reset = 1'b0;
        cycles(30);
        check("midreset_no_word", valid_cycles - vc0, 0);

        // ena low for 20 cycles inside a frame
        rx_ready = 1'b1;
        vc0 = valid_cycles;
        exp_q.push_back(8'h96);
        fork
            send_frame(8'h96, 1'b1);
            begin
                cycles(30);
                ena = 1'b0;
                cycles(20);
                ena = 1'b1;
            end
        join
        cycles(10);
        check("ena_stretch_valid", valid_cycles - vc0, 1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
